p405s_icu_line_fill_seq: RTL

- Line-fill sequencer for the ICU datapath. It sits directly upstream of the 32-bit ICU datapath register (clock CB, enable E1) and drives that register's D and E1 inputs.
- Issues a critical-word-first PLB line read on an ICU miss and collects the 8 returning words into an internal line buffer.
- Forwards the demanded word to the datapath register the same cycle it arrives. Later demand fetches to the filling line are served from the buffer.

---
 rtl/p405s_icu_line_fill_seq_pkg.sv | 26 ++
 rtl/p405s_icu_line_fill_seq_if.sv | 42 ++++
 rtl/p405s_icu_fill_buf.sv | 46 ++++
 rtl/p405s_icu_line_fill_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/p405s_icu_line_fill_seq_pkg.sv
// Shared types and constants for the ICU line-fill sequencer.
// Combinational only; no latency or backpressure of its own.
package p405s_icu_pkg;

  localparam int WORDS   = 8;
  localparam int LADDR_W = 27;
  localparam int WIDX_W  = $clog2(WORDS);
  localparam int PADDR_W = LADDR_W + WIDX_W;
  localparam int LINE_W  = WORDS * 32;

  typedef logic [WIDX_W-1:0] widx_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fill_state_e;

  // Word indices wrap modulo the line length.
  function automatic widx_t widx_inc(input widx_t i);
    return i + widx_t'(1);
  endfunction

endpackage

// File: rtl/p405s_icu_line_fill_seq_if.sv
// Miss/PLB/fetch/datapath signal bundle for the line-fill sequencer.
// master = sequencer side, slave = ICU control, PLB and datapath side.
interface p405s_icu_line_fill_seq_if;
  import p405s_icu_pkg::*;

  logic               fillReq;
  logic [LADDR_W-1:0] fillAddr;
  logic [WIDX_W-1:0]  fillWord;
  logic               fillAbort;

  logic               plbReq;
  logic [PADDR_W-1:0] plbAddr;
  logic               plbAddrAck;
  logic               plbRdDAck;
  logic [31:0]        plbRdData;

  logic               fetchReq;
  logic [WIDX_W-1:0]  fetchWord;

  logic [31:0]        D;
  logic               E1;
  logic               lineDone;
  logic [LINE_W-1:0]  lineData;
  logic               busy;

  modport master (
    input  fillReq, fillAddr, fillWord, fillAbort,
    input  plbAddrAck, plbRdDAck, plbRdData,
    input  fetchReq, fetchWord,
    output plbReq, plbAddr,
    output D, E1, lineDone, lineData, busy
  );

  modport slave (
    output fillReq, fillAddr, fillWord, fillAbort,
    output plbAddrAck, plbRdDAck, plbRdData,
    output fetchReq, fetchWord,
    input  plbReq, plbAddr,
    input  D, E1, lineDone, lineData, busy
  );

endinterface

// File: rtl/p405s_icu_fill_buf.sv
// Line buffer: one write port, one indexed read port, per-word valid bits.
// Writes land on the clock edge; reads are combinational; never stalls.
module p405s_icu_fill_buf
  import p405s_icu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clr,
  input  logic              i_wr_en,
  input  widx_t             i_wr_idx,
  input  logic [31:0]       i_wr_dat,
  input  widx_t             i_rd_idx,
  output logic [31:0]       o_rd_dat,
  output logic              o_rd_vld,
  output logic [LINE_W-1:0] o_line
);

  logic [31:0]      r_mem [WORDS];
  logic [WORDS-1:0] r_vld;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld <= '0;
    end else if (i_clr) begin
      r_vld <= '0;
    end else if (i_wr_en) begin
      r_vld[i_wr_idx] <= 1'b1;
    end
  end

  // Data array carries no reset; the valid bits alone qualify its contents.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_idx];
  assign o_rd_vld = r_vld[i_rd_idx];

  // Word 0 occupies the most significant lane (big-endian bit 0 side).
  for (genvar g = 0; g < WORDS; g++) begin : g_line
    assign o_line[LINE_W-1-32*g -: 32] = r_mem[g];
  end

endmodule

// File: rtl/p405s_icu_line_fill_seq.sv
// Critical-word-first line-fill sequencer feeding the ICU datapath register.
// Zero added latency on forwarding; plbReq is held until plbAddrAck, fetch misses drop E1.
module p405s_icu_line_fill_seq
  import p405s_icu_pkg::*;
(
  input  logic                     i_cb,
  input  logic                     i_reset,
  p405s_icu_line_fill_seq_if.master bus
);

  fill_state_e        r_state;
  fill_state_e        w_state_nxt;
  logic [LADDR_W-1:0] r_addr;
  widx_t              r_crit;
  widx_t              r_ptr;
  widx_t              r_cnt;
  logic [31:0]        r_d;

  logic               w_beat;
  logic               w_last_beat;
  logic               w_fill_live;
  logic               w_latch;
  logic               w_clr;
  logic               w_wr;
  logic               w_crit_beat;
  logic [31:0]        w_rd_dat;
  logic               w_rd_vld;
  logic [LINE_W-1:0]  w_line;
  logic               w_fwd_vld;
  logic [31:0]        w_fwd_dat;

  // Beats are counted in FILL and DRAIN; only live FILL beats are stored.
  assign w_beat      = bus.plbRdDAck && ((r_state == ST_FILL) || (r_state == ST_DRAIN));
  assign w_last_beat = w_beat && (r_cnt == widx_t'(WORDS-1));
  assign w_fill_live = (r_state == ST_FILL) && !bus.fillAbort;
  assign w_latch     = (r_state == ST_IDLE) && bus.fillReq;
  assign w_clr       = w_latch || ((r_state == ST_FILL) && bus.fillAbort);
  assign w_wr        = w_fill_live && bus.plbRdDAck;
  assign w_crit_beat = w_wr && (r_cnt == '0);

  p405s_icu_fill_buf u_buf (
    .i_clk    (i_cb),
    .i_reset  (i_reset),
    .i_clr    (w_clr),
    .i_wr_en  (w_wr),
    .i_wr_idx (r_ptr),
    .i_wr_dat (bus.plbRdData),
    .i_rd_idx (bus.fetchWord),
    .o_rd_dat (w_rd_dat),
    .o_rd_vld (w_rd_vld),
    .o_line   (w_line)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_fwd_vld   = 1'b0;
    w_fwd_dat   = r_d;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.fillReq) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.fillAbort)       w_state_nxt = ST_IDLE;
        else if (bus.plbAddrAck) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (w_last_beat)        w_state_nxt = bus.fillAbort ? ST_IDLE : ST_DONE;
        else if (bus.fillAbort) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_last_beat) w_state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Critical beat wins; otherwise a demand fetch takes the arriving beat or the buffer.
    if (w_crit_beat) begin
      w_fwd_vld = 1'b1;
      w_fwd_dat = bus.plbRdData;
    end else if (bus.fetchReq && (w_fill_live || (r_state == ST_DONE))) begin
      if (w_wr && (r_ptr == bus.fetchWord)) begin
        w_fwd_vld = 1'b1;
        w_fwd_dat = bus.plbRdData;
      end else if (w_rd_vld) begin
        w_fwd_vld = 1'b1;
        w_fwd_dat = w_rd_dat;
      end
    end
  end

  always_ff @(posedge i_cb) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fwd_vld) begin
        r_d <= w_fwd_dat;
      end
      if (w_latch) begin
        r_ptr <= bus.fillWord;
        r_cnt <= '0;
      end else if (w_beat) begin
        r_ptr <= widx_inc(r_ptr);
        r_cnt <= widx_inc(r_cnt);
      end
    end
  end

  always_ff @(posedge i_cb) begin
    if (w_latch) begin
      r_addr <= bus.fillAddr;
      r_crit <= bus.fillWord;
    end
  end

  assign bus.plbReq   = (r_state == ST_REQ);
  assign bus.plbAddr  = {r_addr, r_crit};
  assign bus.D        = w_fwd_dat;
  assign bus.E1       = w_fwd_vld;
  assign bus.lineDone = (r_state == ST_DONE);
  assign bus.lineData = w_line;
  assign bus.busy     = (r_state != ST_IDLE);

endmodule
